// File: rtl/ceyloniac_ram_controller.sv
// Purpose : program-load / run controller around a single-port word memory.
// Latency : load and core writes land on the accepting edge; core reads return one cycle later.
// Backpr. : load_ready is high only in LOAD; the core port is accepted only while ram_enable is high.
//
// Ports:
//   clk, reset (async active-low)
//   load_mode, load_valid, load_addr, load_data -> load_ready, load_count
//   run_start, ram_addr, ram_read_enable, ram_write_enable, ram_write_data
//                                               -> ram_enable, ram_read_data
//   addr_error (sticky out-of-range flag), ctrl_state (IDLE=00, LOAD=01, RUN=10)
module ceyloniac_ram_controller #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_mode,
    input  logic                      load_valid,
    input  logic [RAM_ADDR_WIDTH-1:0] load_addr,
    input  logic [RAM_DATA_WIDTH-1:0] load_data,
    output logic                      load_ready,
    input  logic                      run_start,
    output logic                      ram_enable,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic                      ram_read_enable,
    input  logic                      ram_write_enable,
    input  logic [RAM_DATA_WIDTH-1:0] ram_write_data,
    output logic [RAM_DATA_WIDTH-1:0] ram_read_data,
    output logic [RAM_ADDR_WIDTH-1:0] load_count,
    output logic                      addr_error,
    output logic [1:0]                ctrl_state
);

    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t state;

    // Contents are deliberately not reset so a loaded program survives reset.
    logic [RAM_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic load_in_range;
    logic core_in_range;

    // When the memory covers the whole address space every address is legal.
    generate
        if (MEM_DEPTH_LOG2 < RAM_ADDR_WIDTH) begin : g_partial
            assign load_in_range = (load_addr[RAM_ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);
            assign core_in_range = (ram_addr[RAM_ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);
        end else begin : g_full
            assign load_in_range = 1'b1;
            assign core_in_range = 1'b1;
        end
    endgenerate

    logic [MEM_DEPTH_LOG2-1:0] load_idx;
    logic [MEM_DEPTH_LOG2-1:0] core_idx;
    logic                      load_accept;
    logic                      core_active;

    assign load_idx    = load_addr[MEM_DEPTH_LOG2-1:0];
    assign core_idx    = ram_addr[MEM_DEPTH_LOG2-1:0];
    assign load_accept = (state == ST_LOAD) && load_valid;
    assign core_active = (state == ST_RUN);
    assign ctrl_state  = state;

    // Memory write port; LOAD and RUN are exclusive so the two sources never collide.
    // Reset forces IDLE, which blocks both sources while reset is held.
    always_ff @(posedge clk) begin
        if (load_accept && load_in_range) begin
            mem[load_idx] <= load_data;
        end else if (core_active && ram_write_enable && core_in_range) begin
            mem[core_idx] <= ram_write_data;
        end
    end

    // Control FSM with registered ram_enable / load_ready, counter, flag and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            ram_enable    <= 1'b0;
            load_ready    <= 1'b0;
            ram_read_data <= '0;
            load_count    <= '0;
            addr_error    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_mode) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                        ram_enable <= 1'b0;
                        load_count <= '0;
                        addr_error <= 1'b0;
                    end else if (run_start) begin
                        state      <= ST_RUN;
                        ram_enable <= 1'b1;
                        load_ready <= 1'b0;
                    end else begin
                        ram_enable <= 1'b0;
                        load_ready <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        if (load_in_range) begin
                            load_count <= load_count + RAM_ADDR_WIDTH'(1);
                        end else begin
                            addr_error <= 1'b1;
                        end
                    end
                    if (!load_mode) begin
                        state      <= ST_IDLE;
                        load_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Non-blocking read of mem gives read-before-write on a same-address collision.
                    if (ram_read_enable) begin
                        if (core_in_range) begin
                            ram_read_data <= mem[core_idx];
                        end else begin
                            ram_read_data <= '0;
                            addr_error    <= 1'b1;
                        end
                    end
                    if (ram_write_enable && !core_in_range) begin
                        addr_error <= 1'b1;
                    end
                    if (load_mode) begin
                        state      <= ST_IDLE;
                        ram_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    ram_enable <= 1'b0;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceyloniac_ram_controller.sv
// Purpose : self-checking bench for ceyloniac_ram_controller (default and 4-bit wrap configs).
// Latency : model advances once per rising edge; outputs sampled 1 time unit after the edge.
// Backpr. : none; stimulus is applied open-loop every cycle.
module tb_ceyloniac_ram_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_mode, load_valid, run_start;
    logic [15:0] load_addr, ram_addr;
    logic [31:0] load_data, ram_write_data;
    logic        ram_read_enable, ram_write_enable;
    logic        load_ready, ram_enable, addr_error;
    logic [31:0] ram_read_data;
    logic [15:0] load_count;
    logic [1:0]  ctrl_state;

    // Small instance for the counter-wrap check.
    logic       w_load_mode, w_load_valid, w_run_start;
    logic [3:0] w_load_addr, w_ram_addr;
    logic [7:0] w_load_data, w_ram_write_data;
    logic       w_ram_read_enable, w_ram_write_enable;
    logic       w_load_ready, w_ram_enable, w_addr_error;
    logic [7:0] w_ram_read_data;
    logic [3:0] w_load_count;
    logic [1:0] w_ctrl_state;

    always #5 clk = ~clk;

    ceyloniac_ram_controller dut (
        .clk(clk), .reset(reset),
        .load_mode(load_mode), .load_valid(load_valid), .load_addr(load_addr),
        .load_data(load_data), .load_ready(load_ready), .run_start(run_start),
        .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable), .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data), .load_count(load_count),
        .addr_error(addr_error), .ctrl_state(ctrl_state)
    );

    ceyloniac_ram_controller #(
        .RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(4), .MEM_DEPTH_LOG2(4)
    ) dut_w (
        .clk(clk), .reset(reset),
        .load_mode(w_load_mode), .load_valid(w_load_valid), .load_addr(w_load_addr),
        .load_data(w_load_data), .load_ready(w_load_ready), .run_start(w_run_start),
        .ram_enable(w_ram_enable), .ram_addr(w_ram_addr), .ram_read_enable(w_ram_read_enable),
        .ram_write_enable(w_ram_write_enable), .ram_write_data(w_ram_write_data),
        .ram_read_data(w_ram_read_data), .load_count(w_load_count),
        .addr_error(w_addr_error), .ctrl_state(w_ctrl_state)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: mode (0 idle, 1 load, 2 run), memory image with known-flags.
    int          m_mode;
    logic [31:0] m_mem [1024];
    bit          m_known [1024];
    logic [15:0] m_cnt;
    bit          m_err;
    logic [31:0] m_rd;
    bit          m_rd_known;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_err = 0; m_rd = 0; m_rd_known = 1;
    endtask

    // Apply this cycle's inputs to the model as of the coming edge.
    task automatic model_edge();
        int next_mode;
        next_mode = m_mode;
        if (m_mode == 0) begin
            if (load_mode) begin
                next_mode = 1; m_cnt = 0; m_err = 0;
            end else if (run_start) begin
                next_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (load_valid) begin
                if (load_addr < 16'd1024) begin
                    m_mem[load_addr[9:0]] = load_data;
                    m_known[load_addr[9:0]] = 1;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (!load_mode) next_mode = 0;
        end else begin
            if (ram_read_enable) begin
                if (ram_addr < 16'd1024) begin
                    m_rd = m_mem[ram_addr[9:0]];
                    m_rd_known = m_known[ram_addr[9:0]];
                end else begin
                    m_rd = 0; m_rd_known = 1; m_err = 1;
                end
            end
            if (ram_write_enable) begin
                if (ram_addr < 16'd1024) begin
                    m_mem[ram_addr[9:0]] = ram_write_data;
                    m_known[ram_addr[9:0]] = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (load_mode) next_mode = 0;
        end
        m_mode = next_mode;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 64'(ctrl_state), 64'(m_mode));
        chk({tag, ".ram_enable"}, 64'(ram_enable), 64'(m_mode == 2));
        chk({tag, ".load_ready"}, 64'(load_ready), 64'(m_mode == 1));
        chk({tag, ".load_count"}, 64'(load_count), 64'(m_cnt));
        chk({tag, ".addr_error"}, 64'(addr_error), 64'(m_err));
        if (m_rd_known) chk({tag, ".rd_data"}, 64'(ram_read_data), 64'(m_rd));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        load_mode = 0; load_valid = 0; run_start = 0;
        load_addr = 0; load_data = 0; ram_addr = 0; ram_write_data = 0;
        ram_read_enable = 0; ram_write_enable = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_known[i] = 0;
            m_mem[i] = 0;
        end
        idle_inputs();
        w_load_mode = 0; w_load_valid = 0; w_run_start = 0; w_load_addr = 0;
        w_load_data = 0; w_ram_addr = 0; w_ram_write_data = 0;
        w_ram_read_enable = 0; w_ram_write_enable = 0;
        reset = 0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        step("idle");

        // Load then run
        load_mode = 1;
        step("enter_load");
        load_valid = 1; load_addr = 16'h0000; load_data = 32'h8C010004;
        step("load0");
        load_addr = 16'h0001; load_data = 32'h00000000;
        step("load1");
        load_valid = 0; load_mode = 0;
        step("exit_load");
        run_start = 1;
        step("enter_run");
        run_start = 0; ram_read_enable = 1; ram_addr = 16'h0000;
        step("read0");
        chk("lr_rd_data", 64'(ram_read_data), 64'h8C010004);
        chk("lr_load_count", 64'(load_count), 64'd2);
        chk("lr_ram_enable", 64'(ram_enable), 64'd1);

        // Read-during-write
        ram_read_enable = 0; ram_write_enable = 1; ram_addr = 16'd5; ram_write_data = 32'h11;
        step("wr5_11");
        ram_read_enable = 1; ram_write_data = 32'h22;
        step("rdw5");
        chk("rdw_old", 64'(ram_read_data), 64'h11);
        ram_write_enable = 0;
        step("rd5_after");
        chk("rdw_new", 64'(ram_read_data), 64'h22);

        // Out-of-range load, flag persists into RUN, clears on next LOAD entry
        ram_read_enable = 0; load_mode = 1;
        step("run_to_idle");
        step("idle_to_load");
        load_valid = 1; load_addr = 16'h0400; load_data = 32'hBAD0BAD0;
        step("oor_load");
        chk("oor_err", 64'(addr_error), 64'd1);
        chk("oor_cnt", 64'(load_count), 64'd0);
        load_valid = 0; load_mode = 0;
        step("oor_exit");
        run_start = 1;
        step("oor_run");
        run_start = 0;
        chk("oor_err_run", 64'(addr_error), 64'd1);
        load_mode = 1;
        step("oor_idle");
        step("oor_reload");
        chk("oor_err_clr", 64'(addr_error), 64'd0);
        load_mode = 0;
        step("oor_idle2");
        run_start = 1;
        step("abort_run");
        run_start = 0;

        // Abort during RUN; writes outside RUN are ignored
        ram_write_enable = 1; ram_addr = 16'd7; ram_write_data = 32'hAA; load_mode = 1;
        step("abort");
        chk("abort_en", 64'(ram_enable), 64'd0);
        ram_addr = 16'd5; ram_write_data = 32'hDEAD;
        step("abort_idle_wr");
        step("abort_load_wr");
        load_mode = 0;
        step("abort_idle2");
        run_start = 1;
        step("abort_rerun");
        run_start = 0; ram_write_enable = 0; ram_read_enable = 1;
        step("abort_rd5");
        chk("abort_mem5", 64'(ram_read_data), 64'h22);

        // Async reset mid-cycle in RUN; memory persists
        ram_read_enable = 0;
        step("pre_reset");
        #3;
        reset = 0;
        model_reset();
        #1;
        chk("arst_state", 64'(ctrl_state), 64'd0);
        chk("arst_en", 64'(ram_enable), 64'd0);
        chk("arst_rdy", 64'(load_ready), 64'd0);
        chk("arst_rd", 64'(ram_read_data), 64'd0);
        chk("arst_cnt", 64'(load_count), 64'd0);
        chk("arst_err", 64'(addr_error), 64'd0);
        @(posedge clk); #1;
        reset = 1;
        run_start = 1;
        step("arst_run");
        run_start = 0; ram_read_enable = 1; ram_addr = 16'd5;
        step("arst_rd5");
        chk("arst_mem5", 64'(ram_read_data), 64'h22);
        ram_read_enable = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) load_mode = ~load_mode;
            run_start        = ($urandom_range(0, 3) == 0);
            load_valid       = $urandom_range(0, 1);
            load_addr        = ($urandom_range(0, 9) == 0) ? 16'(16'h0400 + $urandom_range(0, 255))
                                                          : 16'($urandom_range(0, 15));
            load_data        = $urandom;
            ram_read_enable  = $urandom_range(0, 1);
            ram_write_enable = $urandom_range(0, 1);
            ram_addr         = ($urandom_range(0, 9) == 0) ? 16'(16'hF000 + $urandom_range(0, 255))
                                                          : 16'($urandom_range(0, 15));
            ram_write_data   = $urandom;
            step("rand");
        end
        idle_inputs();

        // Counter wrap on the 4-bit instance: 17 accepted words -> count 1
        w_load_mode = 1;
        @(posedge clk); #1;
        chk("w_load_state", 64'(w_ctrl_state), 64'd1);
        chk("w_cnt_clear", 64'(w_load_count), 64'd0);
        w_load_valid = 1;
        for (int i = 0; i < 17; i++) begin
            w_load_addr = 4'(i % 16);
            w_load_data = 8'(i);
            @(posedge clk); #1;
            chk("w_cnt", 64'(w_load_count), 64'((i + 1) % 16));
        end
        chk("w_cnt_final", 64'(w_load_count), 64'd1);
        chk("w_err", 64'(w_addr_error), 64'd0);
        w_load_valid = 0; w_load_mode = 0;
        @(posedge clk); #1;
        w_run_start = 1;
        @(posedge clk); #1;
        w_run_start = 0; w_ram_read_enable = 1; w_ram_addr = 4'd0;
        @(posedge clk); #1;
        chk("w_rd0", 64'(w_ram_read_data), 64'd16);
        w_ram_addr = 4'd9;
        @(posedge clk); #1;
        chk("w_rd9", 64'(w_ram_read_data), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
